// File: rtl/usb_rx_bit_recovery.sv
// USB full-speed receive front end: line synchronizer, edge-driven bit timing
// recovery, NRZI decode, bit-stuff / stuff-error detection and EOP detection.
module usb_rx_bit_recovery #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 3,
  parameter int unsigned STUFF_RUN    = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus_in,
  input  logic d_minus_in,
  input  logic rx_enable,
  output logic d_edge,
  output logic shift_enable,
  output logic d_orig,
  output logic bit_stuff,
  output logic eop,
  output logic stuff_err
);

  localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(STUFF_RUN + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_SMP = TW'(SAMPLE_POINT);
  localparam logic [CW-1:0] ONES_MAX  = CW'(STUFF_RUN);

  typedef enum logic [1:0] {IDLE, RUN, EOP_WAIT} state_t;

  state_t        state;
  logic          dp_meta, dp_sync, dm_meta, dm_sync;
  logic          d_plus_prev, prev_bit;
  logic [TW-1:0] timer;
  logic [CW-1:0] ones_cnt;
  logic          sample, se0, bit_val, stuff_now;

  // Synchronizers reset to the idle J level so reset release is edge-free.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_meta     <= 1'b1;
      dp_sync     <= 1'b1;
      dm_meta     <= 1'b0;
      dm_sync     <= 1'b0;
      d_plus_prev <= 1'b1;
    end else begin
      dp_meta     <= d_plus_in;
      dp_sync     <= dp_meta;
      dm_meta     <= d_minus_in;
      dm_sync     <= dm_meta;
      d_plus_prev <= dp_sync;
    end
  end

  assign d_edge = (dp_sync != d_plus_prev);

  always_comb begin
    sample    = (state == RUN) && (timer == TIMER_SMP);
    se0       = !dp_sync && !dm_sync;
    bit_val   = (dp_sync == prev_bit);
    stuff_now = (ones_cnt == ONES_MAX);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      timer        <= '0;
      ones_cnt     <= '0;
      prev_bit     <= 1'b1;
      shift_enable <= 1'b0;
      d_orig       <= 1'b0;
      bit_stuff    <= 1'b0;
      eop          <= 1'b0;
      stuff_err    <= 1'b0;
    end else begin
      shift_enable <= 1'b0;
      d_orig       <= 1'b0;
      bit_stuff    <= 1'b0;
      eop          <= 1'b0;
      stuff_err    <= 1'b0;
      if (!rx_enable) begin
        state    <= IDLE;
        timer    <= '0;
        ones_cnt <= '0;
        prev_bit <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (d_edge) begin
              state <= RUN;
              timer <= TW'(1);
            end
          end
          RUN: begin
            // Edge resync wins over wrap; the sample still uses the current count.
            if (d_edge)                  timer <= TW'(1);
            else if (timer == TIMER_MAX) timer <= '0;
            else                         timer <= timer + 1'b1;
            if (sample) begin
              if (se0) begin
                eop      <= 1'b1;
                ones_cnt <= '0;
                prev_bit <= 1'b1;
                state    <= EOP_WAIT;
              end else begin
                shift_enable <= 1'b1;
                d_orig       <= bit_val;
                prev_bit     <= dp_sync;
                if (stuff_now) begin
                  bit_stuff <= 1'b1;
                  stuff_err <= bit_val;
                  ones_cnt  <= '0;
                end else if (bit_val) begin
                  ones_cnt <= ones_cnt + 1'b1;
                end else begin
                  ones_cnt <= '0;
                end
              end
            end
          end
          EOP_WAIT: begin
            if (dp_sync && !dm_sync) begin
              state <= IDLE;
              timer <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
